// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and bit-timing helper.
package uart_pkg;

   // Payload bits per 8N1 frame.
   localparam int unsigned DataBits = 8;
   localparam int unsigned IdxW     = $clog2(DataBits);

   // Receiver/transmitter line states.
   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } uart_state_e;

   // Clock cycles per serial bit; integer division, the caller keeps the result >= 2.
   function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle-high line level.
module uart_rx_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   // Shift the raw line through two flops; reset to 1 so no false start bit follows reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-byte valid/ready holding register, framing-error pulse
// and sticky overrun flag.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned Freq = 100_000_000,
   parameter int unsigned Baud = 115_200
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int unsigned ClksPerBit = clks_per_bit(Freq, Baud);
   localparam int unsigned Half       = ClksPerBit / 2;
   localparam int unsigned CntW       = $clog2(ClksPerBit);

   localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(DataBits - 1);

   logic                rx_s;

   uart_state_e         state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [DataBits-1:0] shift_q, shift_d;
   logic                deliver_q, deliver_d;
   logic                frame_err_q, frame_err_d;

   logic [7:0]          data_q, data_d;
   logic                valid_q, valid_d;
   logic                overrun_q, overrun_d;

   uart_rx_sync u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (rx_i),
      .q_o    (rx_s)
   );

   // Frame FSM, bit counter and shifter state registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         deliver_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         deliver_q   <= deliver_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state logic: start is checked mid-bit, data/stop one full bit period later each.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      deliver_d   = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!rx_s) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end

         StStart: begin
            if (cnt_q == HalfLast) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = StData;
                  idx_d   = '0;
               end else begin
                  // Line went back high before mid-start: treat as a glitch.
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StData: begin
            if (cnt_q == BitLast) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IdxLast) begin
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StStop: begin
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               if (rx_s) begin
                  deliver_d = 1'b1;
                  state_d   = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StBreak: begin
            // Hold here while the line stays low so a break reports only one error.
            if (rx_s) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Holding register and overrun flag state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   // Consume on valid&&ready; a delivery in the same cycle refills the register.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      if (valid_q && ready_i) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end

      if (deliver_q) begin
         if (!valid_q || ready_i) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            // Register still owned by the consumer: drop the new byte.
            overrun_d = 1'b1;
         end
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign overrun_o   = overrun_q;
   assign frame_err_o = frame_err_q;
   assign busy_o      = (state_q != StIdle);

endmodule
